// File: rtl/adc_spi_pkg.sv
// Shared definitions for the AD7928-style ADC SPI responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   state_t         responder frame state
//   FRAME_BITS      SPI frame length in sclk falling edges
//   WRITE..SHADOW   bit positions inside the 16-bit control word on din
//   CTRL_LSB/CTRL_W slice of the control word kept as ctrl_word
//   seq_enabled()   sequencer enable test on a stored ctrl_word
package adc_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_DONE    = 2'd2,
        ST_WAIT_CS = 2'd3
    } state_t;

    localparam int FRAME_BITS = 16;

    // Control-word bit positions, as they appear in the received rx word.
    localparam int WRITE   = 15;
    localparam int SEQ     = 14;
    localparam int ADDR_HI = 12;
    localparam int ADDR_LO = 10;
    localparam int SHADOW  = 7;

    // ctrl_word keeps rx[15:4]; the low nibble of the frame is don't-care.
    localparam int CTRL_LSB = 4;
    localparam int CTRL_W   = FRAME_BITS - CTRL_LSB;

    // The stored ctrl_word is rx shifted down by CTRL_LSB, so the SEQ and
    // SHADOW bits move down by the same amount.
    function automatic logic seq_enabled(input logic [CTRL_W-1:0] ctrl);
        return ctrl[SEQ - CTRL_LSB] & ~ctrl[SHADOW - CTRL_LSB];
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with rise/fall pulse generation for one async input.
// Latency: level valid STAGES cycles after pin change; pulses in that same cycle.
// Backpressure: none; free-running sampler.
//
// Ports:
//   i_clk, i_rst_n  clock and async active-low reset
//   i_d             asynchronous input pin
//   o_level         synchronized level
//   o_rise/o_fall   single-cycle pulses on synchronized level transitions
module sync_edge #(
    parameter int   STAGES  = 2,
    // Reset value chosen per pin so that reset itself never fabricates an
    // edge the consumer would act on (sclk idles high, cs_n resets low so a
    // cs_n already held low cannot look like a fresh frame start).
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI slave model of an 8-channel 12-bit ADC: decodes control words, returns samples.
// Latency: dout updates 1 cycle after a detected sclk fall (SYNC_STAGES+1 after the pin).
// Backpressure: none; the SPI master owns timing, clk_clk must be >= 8x sclk.
//
// Ports:
//   clk_clk, reset_reset_n      system clock, async active-low reset
//   sample_data                 per-channel samples, channel n at [n*DATA_WIDTH +: DATA_WIDTH]
//   adc_interface_sclk/cs_n/din SPI inputs from the master (asynchronous)
//   adc_interface_dout, dout_oe SPI response bit and its output enable
//   cur_addr                    channel returned by the next frame
//   ctrl_word                   bits [15:4] of the last written control word
//   frame_done                  one-cycle pulse per completed 16-edge frame
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int NUM_CHANNELS = 8,
    parameter int DATA_WIDTH   = 12,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                               clk_clk,
    input  logic                               reset_reset_n,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] sample_data,
    input  logic                               adc_interface_sclk,
    input  logic                               adc_interface_cs_n,
    input  logic                               adc_interface_din,
    output logic                               adc_interface_dout,
    output logic                               dout_oe,
    output logic [$clog2(NUM_CHANNELS)-1:0]    cur_addr,
    output logic [CTRL_W-1:0]                  ctrl_word,
    output logic                               frame_done
);

    localparam int ADDR_W = $clog2(NUM_CHANNELS);

    // ------------------------------------------------------------------
    // Input synchronization and edge detection
    // ------------------------------------------------------------------
    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_cs_lvl, w_cs_rise, w_cs_fall;
    logic w_din_lvl, w_din_rise, w_din_fall;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
        .i_clk   (clk_clk),
        .i_rst_n (reset_reset_n),
        .i_d     (adc_interface_sclk),
        .o_level (w_sclk_lvl),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
        .i_clk   (clk_clk),
        .i_rst_n (reset_reset_n),
        .i_d     (adc_interface_cs_n),
        .o_level (w_cs_lvl),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
        .i_clk   (clk_clk),
        .i_rst_n (reset_reset_n),
        .i_d     (adc_interface_din),
        .o_level (w_din_lvl),
        .o_rise  (w_din_rise),
        .o_fall  (w_din_fall)
    );

    // Only falling sclk and both cs_n edges drive the frame logic; the
    // remaining sync outputs exist because the synchronizer is shared.
    logic w_unused;
    assign w_unused = ^{w_sclk_lvl, w_sclk_rise, w_cs_lvl, w_din_rise, w_din_fall};

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic [FRAME_BITS-1:0]   r_tx;
    logic [FRAME_BITS-1:0]   r_rx;
    logic [4:0]              r_cnt;
    logic [ADDR_W-1:0]       r_cur_addr;
    logic [CTRL_W-1:0]       r_ctrl;

    logic [DATA_WIDTH-1:0]   w_sample;
    logic [FRAME_BITS-1:0]   w_tx_load;
    logic [FRAME_BITS-1:0]   w_rx_next;
    logic                    w_last_edge;

    assign w_sample    = sample_data[r_cur_addr*DATA_WIDTH +: DATA_WIDTH];
    assign w_tx_load   = FRAME_BITS'({1'b0, r_cur_addr, w_sample});
    assign w_rx_next   = {r_rx[FRAME_BITS-2:0], w_din_lvl};
    assign w_last_edge = (r_cnt == 5'(FRAME_BITS - 1));

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state    <= ST_IDLE;
            r_tx       <= '0;
            r_rx       <= '0;
            r_cnt      <= '0;
            r_cur_addr <= '0;
            r_ctrl     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Sample is captured here once; later sample_data changes
                    // cannot disturb the frame in flight.
                    if (w_cs_fall) begin
                        r_tx    <= w_tx_load;
                        r_rx    <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    // cs_n rise takes priority over a coincident sclk fall,
                    // so a short frame always aborts cleanly.
                    if (w_cs_rise) begin
                        r_state <= ST_IDLE;
                    end else if (w_sclk_fall) begin
                        r_rx  <= w_rx_next;
                        r_tx  <= {r_tx[FRAME_BITS-2:0], 1'b0};
                        r_cnt <= r_cnt + 5'd1;
                        if (w_last_edge) begin
                            r_state <= ST_DONE;
                            // Registers are committed on the transition so the
                            // new values appear in the same cycle as frame_done.
                            if (w_rx_next[WRITE]) begin
                                r_cur_addr <= w_rx_next[ADDR_HI:ADDR_LO];
                                r_ctrl     <= w_rx_next[FRAME_BITS-1:CTRL_LSB];
                            end else if (seq_enabled(r_ctrl)) begin
                                r_cur_addr <= r_cur_addr + 1'b1;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    // A cs_n rise landing in this single cycle must not be
                    // lost, or the responder would wait for a second rise.
                    r_state <= w_cs_rise ? ST_IDLE : ST_WAIT_CS;
                end

                ST_WAIT_CS: begin
                    // Extra sclk falls are ignored; tx has already drained to 0.
                    if (w_cs_rise) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dout_oe            = (r_state != ST_IDLE);
    assign adc_interface_dout = dout_oe & r_tx[FRAME_BITS-1];
    assign frame_done         = (r_state == ST_DONE);
    assign cur_addr           = r_cur_addr;
    assign ctrl_word          = r_ctrl;

endmodule
